// File: rtl/booth_multiplier_seq_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier:
// FSM state encodings, Booth-pair opcodes and the pair decoder.
package booth_multiplier_seq_pkg;

  typedef enum logic {
    BOOTH_IDLE = 1'b0,
    BOOTH_RUN  = 1'b1
  } booth_state_t;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'd0,
    BOOTH_ADD = 2'd1,
    BOOTH_SUB = 2'd2
  } booth_op_t;

  // {Q[0], q_1} = 01 adds M, 10 subtracts M, 00/11 leave A alone.
  function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
    case ({q0, q_1})
      2'b01:   return BOOTH_ADD;
      2'b10:   return BOOTH_SUB;
      default: return BOOTH_NOP;
    endcase
  endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/sub of M into A, then an
// arithmetic right shift of the concatenation {A, Q, q_1}.
module booth_step
  import booth_multiplier_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic signed [WIDTH:0] a,
  input  logic        [WIDTH:0] q,
  input  logic                  q_1,
  input  logic signed [WIDTH:0] m,
  output logic signed [WIDTH:0] a_next,
  output logic        [WIDTH:0] q_next,
  output logic                  q_1_next
);

  logic signed [WIDTH:0] acc;

  always_comb begin
    acc = a;
    case (booth_decode(q[0], q_1))
      BOOTH_ADD: acc = a + m;
      BOOTH_SUB: acc = a - m;
      default:   acc = a;
    endcase
    // The acc msb is replicated; Q[0] falls into q_1.
    {a_next, q_next, q_1_next} = {acc[WIDTH], acc, q};
  end

endmodule

// File: rtl/booth_multiplier_seq.sv
// Multi-cycle radix-2 Booth multiplier with start/busy/done handshake.
// One add/sub plus arithmetic shift per clock; signed or unsigned operands.
module booth_multiplier_seq
  import booth_multiplier_seq_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter bit SIGNED = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     Md,
  input  logic [WIDTH-1:0]     Mr,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   Out
);

  localparam int ITER  = SIGNED ? WIDTH : WIDTH + 1;
  localparam int CNT_W = $clog2(ITER + 1);

  booth_state_t state, state_nxt;

  logic signed [WIDTH:0] m, a, a_nxt;
  logic        [WIDTH:0] q, q_nxt;
  logic                  q_1, q_1_nxt;
  logic [CNT_W-1:0]      cnt;
  logic                  accept, last_step;
  logic [2*WIDTH-1:0]    product;

  function automatic logic [WIDTH:0] ext(input logic [WIDTH-1:0] v);
    return {(SIGNED ? v[WIDTH-1] : 1'b0), v};
  endfunction

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a        (a),
    .q        (q),
    .q_1      (q_1),
    .m        (m),
    .a_next   (a_nxt),
    .q_next   (q_nxt),
    .q_1_next (q_1_nxt)
  );

  // Signed mode stops after WIDTH shifts, so the unexamined extension bit of
  // Q still sits in Q[0]; unsigned mode consumes all WIDTH+1 bits of Q.
  always_comb begin
    if (SIGNED) product = {a_nxt[WIDTH-1:0], q_nxt[WIDTH:1]};
    else        product = {a_nxt[WIDTH-2:0], q_nxt};
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last_step = 1'b0;
    case (state)
      BOOTH_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = BOOTH_RUN;
        end
      end
      BOOTH_RUN: begin
        if (cnt == CNT_W'(1)) begin
          last_step = 1'b1;
          state_nxt = BOOTH_IDLE;
        end
      end
      default: state_nxt = BOOTH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= BOOTH_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m    <= '0;
      a    <= '0;
      q    <= '0;
      q_1  <= 1'b0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      Out  <= '0;
    end else begin
      done <= last_step;
      if (accept) begin
        m    <= ext(Md);
        a    <= '0;
        q    <= ext(Mr);
        q_1  <= 1'b0;
        cnt  <= CNT_W'(ITER);
        busy <= 1'b1;
      end else if (state == BOOTH_RUN) begin
        a   <= a_nxt;
        q   <= q_nxt;
        q_1 <= q_1_nxt;
        cnt <= cnt - CNT_W'(1);
        if (last_step) begin
          busy <= 1'b0;
          Out  <= product;
        end
      end
    end
  end

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Self-checking bench for booth_multiplier_seq: 4-bit signed, 4-bit unsigned
// and 8-bit signed instances against an integer-arithmetic reference.
module tb_booth_multiplier_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       s4_start, s4_busy, s4_done;
  logic [3:0] s4_md, s4_mr;
  logic [7:0] s4_out;

  logic       u4_start, u4_busy, u4_done;
  logic [3:0] u4_md, u4_mr;
  logic [7:0] u4_out;

  logic        s8_start, s8_busy, s8_done;
  logic [7:0]  s8_md, s8_mr;
  logic [15:0] s8_out;

  int vectors = 0;
  int miscompares = 0;

  booth_multiplier_seq #(.WIDTH(4), .SIGNED(1'b1)) u_s4 (
    .clk(clk), .rst(rst), .start(s4_start), .Md(s4_md), .Mr(s4_mr),
    .busy(s4_busy), .done(s4_done), .Out(s4_out));

  booth_multiplier_seq #(.WIDTH(4), .SIGNED(1'b0)) u_u4 (
    .clk(clk), .rst(rst), .start(u4_start), .Md(u4_md), .Mr(u4_mr),
    .busy(u4_busy), .done(u4_done), .Out(u4_out));

  booth_multiplier_seq #(.WIDTH(8), .SIGNED(1'b1)) u_s8 (
    .clk(clk), .rst(rst), .start(s8_start), .Md(s8_md), .Mr(s8_mr),
    .busy(s8_busy), .done(s8_done), .Out(s8_out));

  // Reference product: interpret operands as w-bit integers, multiply, keep 2w bits.
  function automatic logic [15:0] ref_mul(input int w, input bit sgn,
                                          input logic [7:0] x, input logic [7:0] y);
    int a, b, p, mask;
    a = int'(x);
    b = int'(y);
    if (sgn && x[w-1]) a = a - (1 << w);
    if (sgn && y[w-1]) b = b - (1 << w);
    p = a * b;
    mask = (1 << (2 * w)) - 1;
    return 16'(p & mask);
  endfunction

  // Drivers: issue one start, return result and edges from accept to done.
  task automatic op_s4(input logic [3:0] md, input logic [3:0] mr,
                       output logic [7:0] res, output int lat);
    @(negedge clk);
    s4_start = 1'b1; s4_md = md; s4_mr = mr;
    @(negedge clk);
    s4_start = 1'b0;
    lat = 0;
    while (!s4_done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = s4_out;
  endtask

  task automatic op_u4(input logic [3:0] md, input logic [3:0] mr,
                       output logic [7:0] res, output int lat);
    @(negedge clk);
    u4_start = 1'b1; u4_md = md; u4_mr = mr;
    @(negedge clk);
    u4_start = 1'b0;
    lat = 0;
    while (!u4_done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = u4_out;
  endtask

  task automatic op_s8(input logic [7:0] md, input logic [7:0] mr,
                       output logic [15:0] res, output int lat);
    @(negedge clk);
    s8_start = 1'b1; s8_md = md; s8_mr = mr;
    @(negedge clk);
    s8_start = 1'b0;
    lat = 0;
    while (!s8_done && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    res = s8_out;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (s4_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", s4_busy); end
    vectors++;
    if (s4_done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", s4_done); end
    vectors++;
    if (s4_out !== 8'h00) begin miscompares++; $display("FAIL reset_out_s4 got %h want 00", s4_out); end
    vectors++;
    if (u4_out !== 8'h00) begin miscompares++; $display("FAIL reset_out_u4 got %h want 00", u4_out); end
    vectors++;
    if (s8_out !== 16'h0000) begin miscompares++; $display("FAIL reset_out_s8 got %h want 0000", s8_out); end
    rst = 1'b0;
  endtask

  task automatic test_directed_s4();
    logic [3:0] mds [5] = '{4'h1, 4'h7, 4'h8, 4'h8, 4'hF};
    logic [3:0] mrs [5] = '{4'h5, 4'h2, 4'h7, 4'h8, 4'h1};
    logic [7:0] exp [5] = '{8'h05, 8'h0E, 8'hC8, 8'h40, 8'hFF};
    logic [7:0] res;
    int lat;
    for (int i = 0; i < 5; i++) begin
      op_s4(mds[i], mrs[i], res, lat);
      vectors++;
      if (lat !== 4) begin miscompares++; $display("FAIL s4_latency[%0d] got %0d want 4", i, lat); end
      vectors++;
      if (res !== exp[i]) begin miscompares++; $display("FAIL s4_product[%0d] got %h want %h", i, res, exp[i]); end
      @(negedge clk);
      vectors++;
      if (s4_done !== 1'b0 || s4_out !== exp[i]) begin
        miscompares++;
        $display("FAIL s4_done_pulse[%0d] got done=%b out=%h want done=0 out=%h", i, s4_done, s4_out, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    s4_start = 1'b1; s4_md = 4'h3; s4_mr = 4'h5;
    @(negedge clk);
    lat = 0;
    while (!s4_done && lat < 20) begin
      s4_md = 4'($urandom); s4_mr = 4'($urandom);
      @(negedge clk);
      lat++;
    end
    vectors++;
    if (lat !== 4) begin miscompares++; $display("FAIL b2b_first_latency got %0d want 4", lat); end
    vectors++;
    if (s4_out !== 8'h0F) begin miscompares++; $display("FAIL b2b_first_product got %h want 0f", s4_out); end
    s4_md = 4'h2; s4_mr = 4'hD;
    @(negedge clk);
    s4_start = 1'b0;
    vectors++;
    if (s4_busy !== 1'b1 || s4_out !== 8'h0F) begin
      miscompares++;
      $display("FAIL b2b_second_accept got busy=%b out=%h want busy=1 out=0f", s4_busy, s4_out);
    end
    lat = 0;
    while (!s4_done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    vectors++;
    if (lat !== 4) begin miscompares++; $display("FAIL b2b_second_latency got %0d want 4", lat); end
    vectors++;
    if (s4_out !== 8'hFA) begin miscompares++; $display("FAIL b2b_second_product got %h want fa", s4_out); end
  endtask

  task automatic test_reset_abort();
    logic [7:0] res;
    int lat;
    bit seen;
    @(negedge clk);
    s4_start = 1'b1; s4_md = 4'h7; s4_mr = 4'h7;
    @(negedge clk);
    s4_start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (s4_busy !== 1'b0 || s4_done !== 1'b0 || s4_out !== 8'h00) begin
      miscompares++;
      $display("FAIL abort_state got busy=%b done=%b out=%h want 0 0 00", s4_busy, s4_done, s4_out);
    end
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (s4_done) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin miscompares++; $display("FAIL abort_no_done got %b want 0", seen); end
    op_s4(4'h7, 4'h7, res, lat);
    vectors++;
    if (lat !== 4 || res !== 8'h31) begin
      miscompares++;
      $display("FAIL abort_fresh_op got lat=%0d out=%h want lat=4 out=31", lat, res);
    end
  endtask

  task automatic test_rst_start_same_edge();
    @(negedge clk);
    rst = 1'b1; s4_start = 1'b1; s4_md = 4'h3; s4_mr = 4'h3;
    @(negedge clk);
    rst = 1'b0; s4_start = 1'b0;
    vectors++;
    if (s4_busy !== 1'b0) begin miscompares++; $display("FAIL rst_wins_busy got %b want 0", s4_busy); end
    repeat (6) @(negedge clk);
    vectors++;
    if (s4_out !== 8'h00) begin miscompares++; $display("FAIL rst_wins_out got %h want 00", s4_out); end
  endtask

  task automatic test_random_s4();
    logic [3:0] md, mr;
    logic [7:0] res, exp;
    int lat;
    for (int i = 0; i < 20; i++) begin
      md = 4'($urandom); mr = 4'($urandom);
      exp = ref_mul(4, 1'b1, {4'h0, md}, {4'h0, mr})[7:0];
      op_s4(md, mr, res, lat);
      vectors++;
      if (lat !== 4 || res !== exp) begin
        miscompares++;
        $display("FAIL s4_random %h*%h got lat=%0d out=%h want lat=4 out=%h", md, mr, lat, res, exp);
      end
    end
  endtask

  task automatic test_unsigned_u4();
    logic [3:0] md, mr;
    logic [7:0] res, exp;
    int lat;
    op_u4(4'hF, 4'hF, res, lat);
    vectors++;
    if (lat !== 5) begin miscompares++; $display("FAIL u4_latency got %0d want 5", lat); end
    vectors++;
    if (res !== 8'hE1) begin miscompares++; $display("FAIL u4_max_product got %h want e1", res); end
    for (int i = 0; i < 15; i++) begin
      md = 4'($urandom); mr = 4'($urandom);
      exp = ref_mul(4, 1'b0, {4'h0, md}, {4'h0, mr})[7:0];
      op_u4(md, mr, res, lat);
      vectors++;
      if (lat !== 5 || res !== exp) begin
        miscompares++;
        $display("FAIL u4_random %h*%h got lat=%0d out=%h want lat=5 out=%h", md, mr, lat, res, exp);
      end
    end
  endtask

  task automatic test_random_s8();
    logic [7:0]  md, mr;
    logic [15:0] res, exp;
    int lat;
    for (int i = 0; i < 40; i++) begin
      case (i)
        0:       begin md = 8'h80; mr = 8'h80; end
        1:       begin md = 8'h7F; mr = 8'h80; end
        2:       begin md = 8'hFF; mr = 8'hFF; end
        default: begin md = 8'($urandom); mr = 8'($urandom); end
      endcase
      exp = ref_mul(8, 1'b1, md, mr);
      op_s8(md, mr, res, lat);
      vectors++;
      if (lat !== 8 || res !== exp) begin
        miscompares++;
        $display("FAIL s8_random %h*%h got lat=%0d out=%h want lat=8 out=%h", md, mr, lat, res, exp);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    s4_start = 1'b0; s4_md = '0; s4_mr = '0;
    u4_start = 1'b0; u4_md = '0; u4_mr = '0;
    s8_start = 1'b0; s8_md = '0; s8_mr = '0;
    test_reset();
    test_directed_s4();
    test_back_to_back();
    test_reset_abort();
    test_rst_start_same_edge();
    test_random_s4();
    test_unsigned_u4();
    test_random_s8();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
